// File: rtl/div_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl_if
// Bundles the EX-stage request, the divider start/ready handshake and the
// HI/LO write-back of the divide issue controller.
//   master : the issue controller (div_issue_ctrl)
//   slave  : its environment (EX stage, divider, HI/LO register file)
// Signals:
//   ex_div_req / ex_signed / ex_op1 / ex_op2 / ex_flush : request from EX
//   div_start / signed_div_o / div_opdata1 / div_opdata2 : command to divider
//   div_ready / div_res                                  : divider response
//   stall_req                                            : pipeline stall
//   hilo_we / hi_o / lo_o                                : HI/LO write-back
//   div_err                                              : sticky watchdog error
// ---------------------------------------------------------------------------
interface div_issue_ctrl_if #(
    parameter int DATA_W = 32
);
    logic                  ex_div_req;
    logic                  ex_signed;
    logic [DATA_W-1:0]     ex_op1;
    logic [DATA_W-1:0]     ex_op2;
    logic                  ex_flush;

    logic                  div_start;
    logic                  signed_div_o;
    logic [DATA_W-1:0]     div_opdata1;
    logic [DATA_W-1:0]     div_opdata2;
    logic                  div_ready;
    logic [2*DATA_W-1:0]   div_res;

    logic                  stall_req;
    logic                  hilo_we;
    logic [DATA_W-1:0]     hi_o;
    logic [DATA_W-1:0]     lo_o;
    logic                  div_err;

    modport master (
        input  ex_div_req, ex_signed, ex_op1, ex_op2, ex_flush,
        input  div_ready, div_res,
        output div_start, signed_div_o, div_opdata1, div_opdata2,
        output stall_req, hilo_we, hi_o, lo_o, div_err
    );

    modport slave (
        output ex_div_req, ex_signed, ex_op1, ex_op2, ex_flush,
        output div_ready, div_res,
        input  div_start, signed_div_o, div_opdata1, div_opdata2,
        input  stall_req, hilo_we, hi_o, lo_o, div_err
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
// Initiator side of the divider start/ready handshake, sitting in EX beside
// the divider. Accepts a DIV/DIVU from EX, drives start/signedness/operands,
// stalls the pipeline while the divide runs, and writes the result back as a
// one-cycle HI/LO write. Handles flushes mid-divide (the divider is still
// driven to completion and its result discarded) and a no-response watchdog.
// Ports:
//   cpu_clk_50M : clock, rising edge
//   cpu_rst     : asynchronous reset, active high
//   bus         : div_issue_ctrl_if.master (request, handshake, write-back)
// All outputs are registered except bus.stall_req.
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 63
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst,
    div_issue_ctrl_if.master      bus
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Value held by the counter during the last permitted wait cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2,
        ABORT   = 2'd3
    } state_t;

    state_t              state_q,   state_d;
    logic                start_q,   start_d;
    logic                sgn_q,     sgn_d;
    logic [DATA_W-1:0]   op1_q,     op1_d;
    logic [DATA_W-1:0]   op2_q,     op2_d;
    logic                hilo_we_q, hilo_we_d;
    logic [DATA_W-1:0]   hi_q,      hi_d;
    logic [DATA_W-1:0]   lo_q,      lo_d;
    logic                err_q,     err_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        sgn_d     = sgn_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        hilo_we_d = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        err_d     = err_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                // div_ready still high means the divider has not returned to
                // its free state after the previous operation.
                if (bus.ex_div_req && !bus.ex_flush && !bus.div_ready) begin
                    start_d = 1'b1;
                    sgn_d   = bus.ex_signed;
                    op1_d   = bus.ex_op1;
                    op2_d   = bus.ex_op2;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                if (bus.ex_flush) begin
                    if (bus.div_ready) begin
                        // Divider already at its end: dropping start frees it.
                        start_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        // Keep start high so the divider can reach its end.
                        cnt_d   = '0;
                        state_d = ABORT;
                    end
                end else if (bus.div_ready) begin
                    lo_d      = bus.div_res[DATA_W-1:0];
                    hi_d      = bus.div_res[2*DATA_W-1:DATA_W];
                    hilo_we_d = 1'b1;
                    start_d   = 1'b0;
                    state_d   = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    start_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RELEASE: begin
                state_d = IDLE;
            end

            ABORT: begin
                if (bus.div_ready) begin
                    start_d = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    start_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                start_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            sgn_q     <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            hilo_we_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            sgn_q     <= sgn_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            hilo_we_q <= hilo_we_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Low in the cycle the result registers so the instruction leaves EX as
    // the HI/LO write lands.
    assign bus.stall_req = ((state_q == IDLE) && bus.ex_div_req && !bus.ex_flush)
                         | ((state_q == BUSY) && !bus.div_ready && !bus.ex_flush)
                         | (((state_q == ABORT) || (state_q == RELEASE)) && bus.ex_div_req);

    assign bus.div_start    = start_q;
    assign bus.signed_div_o = sgn_q;
    assign bus.div_opdata1  = op1_q;
    assign bus.div_opdata2  = op2_q;
    assign bus.hilo_we      = hilo_we_q;
    assign bus.hi_o         = hi_q;
    assign bus.lo_o         = lo_q;
    assign bus.div_err      = err_q;

endmodule
